// File: rtl/adbg_ahb3_mem_slave_if.sv
//============================================================================
// Module      : adbg_ahb3_mem_slave_if
// Description : AHB3-Lite bus bundle between a debug bus master and the
//               adbg_ahb3_mem_slave responder.
//               master modport : drives address/control/write data and the
//                                bus-level HREADY.
//               slave modport  : drives HRDATA, HREADYOUT and HRESP.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface adbg_ahb3_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
               HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

`default_nettype wire

// File: rtl/adbg_ahb3_mem_slave.sv
//============================================================================
// Module      : adbg_ahb3_mem_slave
// Description : AHB3-Lite slave backed by a word-organised memory of
//               MEM_DEPTH x DATA_WIDTH (DATA_WIDTH 32 or 64). Byte, halfword
//               and word transfers, pipelined address/data phases, two-cycle
//               ERROR response for oversize, misaligned or out-of-range
//               accesses, and write-to-read forwarding for back-to-back
//               accesses to the same word.
//               Optional feature macro: ADBG_AHB3_SLV_WAITSTATE_EN
//               (inserts WAIT_STATES wait cycles on every OKAY transfer).
// Ports       : HCLK    - clock, rising edge
//               HRESET  - synchronous active-high reset
//               bus     - AHB3-Lite slave modport (HSEL, HADDR, HWDATA,
//                         HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK,
//                         HREADY in; HRDATA, HREADYOUT, HRESP out)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module adbg_ahb3_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input  wire logic              HCLK,
    input  wire logic              HRESET,
    adbg_ahb3_mem_slave_if.slave   bus
);

    localparam int c_BYTES     = DATA_WIDTH / 8;
    localparam int c_LANE_BITS = $clog2(c_BYTES);
    localparam int c_IDX_BITS  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int c_AW1       = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] c_MEM_BYTES = c_AW1'(MEM_DEPTH * c_BYTES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR1 = 2'd2;
    localparam logic [1:0] S_ERR2 = 2'd3;

    logic [DATA_WIDTH-1:0]  r_mem [MEM_DEPTH];

    logic [1:0]             r_state_q,  w_state_d;
    logic                   r_dph_q,    w_dph_d;     // OKAY data phase outstanding
    logic                   r_write_q,  w_write_d;
    logic [2:0]             r_size_q,   w_size_d;
    logic [c_LANE_BITS-1:0] r_lane_q,   w_lane_d;    // byte offset within word
    logic [c_IDX_BITS-1:0]  r_idx_q,    w_idx_d;     // word index
    logic [DATA_WIDTH-1:0]  r_hrdata_q, w_hrdata_d;

`ifdef ADBG_AHB3_SLV_WAITSTATE_EN
    localparam int c_CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    logic [c_CNT_W-1:0]     r_cnt_q,    w_cnt_d;
`endif

    logic                   w_ready;
    logic                   w_accept;
    logic                   w_misalign;
    logic                   w_addr_err;
    logic                   w_complete;
    logic                   w_wr_en;
    logic                   w_fwd;
    logic [c_IDX_BITS-1:0]  w_acc_idx;
    logic [c_BYTES-1:0]     w_lane_en;
    logic [DATA_WIDTH-1:0]  w_fwd_word;
    logic                   w_unused;

    // HREADYOUT is high only in IDLE and ERR2, so a new address phase can only
    // legitimately be addressed to this slave in those two states.
    assign w_ready   = (r_state_q == S_IDLE) || (r_state_q == S_ERR2);
    assign w_accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1] && w_ready;
    assign w_acc_idx = bus.HADDR[c_LANE_BITS +: c_IDX_BITS];

    // The outstanding OKAY data phase completes in the first IDLE cycle
    // after acceptance (immediately, or after the WAIT cycles).
    assign w_complete = r_dph_q && (r_state_q == S_IDLE);
    assign w_wr_en    = w_complete && r_write_q && !HRESET;

    assign bus.HREADYOUT = w_ready;
    assign bus.HRESP     = (r_state_q == S_ERR1) || (r_state_q == S_ERR2);
    assign bus.HRDATA    = r_hrdata_q;

    assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HMASTLOCK, bus.HTRANS[0],
                        (WAIT_STATES != 0)};

    // Address-phase error decode.
    always_comb begin
        w_misalign = 1'b0;
        for (int i = 0; i < c_LANE_BITS; i++) begin
            if (bus.HADDR[i] && (3'(i) < bus.HSIZE)) begin
                w_misalign = 1'b1;
            end
        end
        w_addr_err = (bus.HSIZE > 3'(c_LANE_BITS)) || w_misalign ||
                     ({1'b0, bus.HADDR} >= c_MEM_BYTES);
    end

    // A lane is enabled when it lies in the same HSIZE-sized block as the
    // registered byte offset.
    always_comb begin
        for (int j = 0; j < c_BYTES; j++) begin
            w_lane_en[j] = (((c_LANE_BITS'(j) ^ r_lane_q) >> r_size_q) == '0);
        end
    end

    // Read data for an address accepted while a write to the same word is
    // landing in memory on the same edge: merge the written lanes.
    always_comb begin
        w_fwd      = w_wr_en && (r_idx_q == w_acc_idx);
        w_fwd_word = r_mem[w_acc_idx];
        for (int j = 0; j < c_BYTES; j++) begin
            if (w_fwd && w_lane_en[j]) begin
                w_fwd_word[8*j +: 8] = bus.HWDATA[8*j +: 8];
            end
        end
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_dph_d    = r_dph_q;
        w_write_d  = r_write_q;
        w_size_d   = r_size_q;
        w_lane_d   = r_lane_q;
        w_idx_d    = r_idx_q;
        w_hrdata_d = r_hrdata_q;
`ifdef ADBG_AHB3_SLV_WAITSTATE_EN
        w_cnt_d    = r_cnt_q;
`endif
        case (r_state_q)
            S_IDLE, S_ERR2: begin
                w_state_d = S_IDLE;
                w_dph_d   = 1'b0;
                if (w_accept) begin
                    if (w_addr_err) begin
                        // Error wins over wait states; nothing is registered
                        // so no memory access follows.
                        w_state_d = S_ERR1;
                    end else begin
                        w_dph_d   = 1'b1;
                        w_write_d = bus.HWRITE;
                        w_size_d  = bus.HSIZE;
                        w_lane_d  = bus.HADDR[c_LANE_BITS-1:0];
                        w_idx_d   = w_acc_idx;
`ifdef ADBG_AHB3_SLV_WAITSTATE_EN
                        if (WAIT_STATES != 0) begin
                            w_state_d = S_WAIT;
                            w_cnt_d   = c_CNT_W'(WAIT_STATES - 1);
                        end else if (!bus.HWRITE) begin
                            w_hrdata_d = w_fwd_word;
                        end
`else
                        if (!bus.HWRITE) begin
                            w_hrdata_d = w_fwd_word;
                        end
`endif
                    end
                end
            end
            S_ERR1: begin
                w_state_d = S_ERR2;
            end
`ifdef ADBG_AHB3_SLV_WAITSTATE_EN
            S_WAIT: begin
                if (r_cnt_q == '0) begin
                    w_state_d = S_IDLE;
                    // No write can complete while waiting, so memory is
                    // already current here.
                    if (!r_write_q) begin
                        w_hrdata_d = r_mem[r_idx_q];
                    end
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
`endif
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state_q  <= S_IDLE;
            r_dph_q    <= 1'b0;
            r_write_q  <= 1'b0;
            r_size_q   <= '0;
            r_lane_q   <= '0;
            r_idx_q    <= '0;
            r_hrdata_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_dph_q    <= w_dph_d;
            r_write_q  <= w_write_d;
            r_size_q   <= w_size_d;
            r_lane_q   <= w_lane_d;
            r_idx_q    <= w_idx_d;
            r_hrdata_q <= w_hrdata_d;
        end
    end

`ifdef ADBG_AHB3_SLV_WAITSTATE_EN
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end
`endif

    // Memory contents are deliberately not reset.
    always_ff @(posedge HCLK) begin
        if (w_wr_en) begin
            for (int j = 0; j < c_BYTES; j++) begin
                if (w_lane_en[j]) begin
                    r_mem[r_idx_q][8*j +: 8] <= bus.HWDATA[8*j +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adbg_ahb3_mem_slave.sv
//============================================================================
// Module      : tb_adbg_ahb3_mem_slave
// Description : Self-checking bench for adbg_ahb3_mem_slave (32-bit data,
//               256 words). A byte-array reference model tracks memory and
//               the last read word; transfers are issued back-to-back.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_adbg_ahb3_mem_slave;

    localparam int c_MEM_BYTES = 1024;
`ifdef ADBG_AHB3_SLV_WAITSTATE_EN
    localparam int c_EXP_WAITS = 2;
`else
    localparam int c_EXP_WAITS = 0;
`endif

    typedef struct {
        bit        sel;
        bit [1:0]  trans;
        bit        write;
        bit [2:0]  size;
        bit [31:0] addr;
        bit [31:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    adbg_ahb3_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    adbg_ahb3_mem_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (256),
        .WAIT_STATES(2)
    ) u_dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus.slave)
    );

    logic [7:0]  m_mem [c_MEM_BYTES];
    logic [31:0] m_rdata;
    logic [31:0] last_obs_rd;
    xfer_t       q[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic xfer_t mk(input bit [1:0] trans, input bit write, input bit [2:0] size,
                                 input bit [31:0] addr, input bit [31:0] wdata);
        xfer_t t;
        t.sel = 1'b1; t.trans = trans; t.write = write;
        t.size = size; t.addr = addr; t.wdata = wdata;
        return t;
    endfunction

    function automatic bit f_is_err(input xfer_t t);
        if (t.size > 3'd2) return 1'b1;
        if ((t.addr % (32'd1 << t.size)) != 0) return 1'b1;
        return (t.addr >= c_MEM_BYTES);
    endfunction

    function automatic logic [31:0] f_model_read(input bit [31:0] addr);
        logic [31:0] w;
        int base;
        base = int'(addr) & ~3;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = m_mem[base + b];
        return w;
    endfunction

    task automatic model_write(input xfer_t t);
        int a;
        for (int b = 0; b < (1 << t.size); b++) begin
            a = int'(t.addr) + b;
            m_mem[a] = t.wdata[8*(a % 4) +: 8];
        end
    endtask

    // Checks every cycle of one data phase, starting just after the edge that
    // opened it, and returns just before the edge that closes it.
    task automatic data_phase(input xfer_t t);
        if (!(t.sel && t.trans[1])) begin
            @(negedge clk);
            check("idle_resp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd2);
            check("idle_hold", bus.HRDATA, m_rdata);
        end else if (f_is_err(t)) begin
            @(negedge clk);
            check("err_cyc1", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd1);
            check("err_hold1", bus.HRDATA, m_rdata);
            @(posedge clk);
            @(negedge clk);
            check("err_cyc2", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd3);
            check("err_hold2", bus.HRDATA, m_rdata);
        end else begin
            for (int w = 0; w < c_EXP_WAITS; w++) begin
                @(negedge clk);
                check("wait_cyc", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd0);
                check("wait_hold", bus.HRDATA, m_rdata);
                @(posedge clk);
            end
            @(negedge clk);
            check("okay_done", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd2);
            if (t.write) begin
                model_write(t);
                check("wr_hold", bus.HRDATA, m_rdata);
            end else begin
                m_rdata     = f_model_read(t.addr);
                last_obs_rd = bus.HRDATA;
                check("rd_data", bus.HRDATA, m_rdata);
            end
        end
    endtask

    // Issues every queued transfer back-to-back: the next address phase is
    // presented during the current data phase.
    task automatic run_queue();
        xfer_t dp, ap, idle;
        bit    more, from_q;
        idle = mk(2'd0, 1'b0, 3'd0, 32'd0, 32'd0);
        idle.sel = 1'b0;
        dp   = idle;
        more = 1'b1;
        while (more) begin
            from_q = (q.size() > 0);
            ap = from_q ? q.pop_front() : idle;
            bus.HSEL   = ap.sel;
            bus.HTRANS = ap.trans;
            bus.HADDR  = ap.addr;
            bus.HWRITE = ap.write;
            bus.HSIZE  = ap.size;
            bus.HBURST = 3'($urandom_range(0, 7));
            bus.HWDATA = dp.write ? dp.wdata : $urandom();
            data_phase(dp);
            @(posedge clk); #1;
            dp   = ap;
            more = from_q;
        end
    endtask

    task automatic random_traffic(input int n);
        xfer_t t;
        int    r;
        for (int i = 0; i < n; i++) begin
            r       = $urandom_range(0, 9);
            t.sel   = ($urandom_range(0, 15) != 0);
            t.trans = (r < 1) ? 2'd0 : (r < 2) ? 2'd1 : (r < 6) ? 2'd2 : 2'd3;
            t.write = 1'($urandom_range(0, 1));
            t.size  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7))
                                                    : 3'($urandom_range(0, 2));
            t.addr  = $urandom_range(0, 32'h43F);
            if ($urandom_range(0, 7) != 0) t.addr &= ~((32'd1 << t.size) - 32'd1);
            t.wdata = $urandom();
            q.push_back(t);
        end
        run_queue();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < c_MEM_BYTES; i++) m_mem[i] = 'x;
        m_rdata = 32'd0;
        last_obs_rd = 32'd0;
        bus.HSEL = 1'b0; bus.HTRANS = 2'd0; bus.HADDR = 32'd0; bus.HWRITE = 1'b0;
        bus.HSIZE = 3'd0; bus.HBURST = 3'd0; bus.HPROT = 4'h3; bus.HMASTLOCK = 1'b0;
        bus.HWDATA = 32'd0;

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_hreadyout", {31'd0, bus.HREADYOUT}, 32'd1);
        check("rst_hresp", {31'd0, bus.HRESP}, 32'd0);
        check("rst_hrdata", bus.HRDATA, 32'd0);
        @(posedge clk); #1;

        // Word write then read.
        q.push_back(mk(2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF));
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h10, 32'd0));
        run_queue();
        check("tp_deadbeef", last_obs_rd, 32'hDEADBEEF);

        // Give the whole memory known contents.
        for (int w = 0; w < 256; w++) q.push_back(mk(2'd2, 1'b1, 3'd2, 32'(w * 4), $urandom()));
        run_queue();

        // Byte and halfword merges.
        q.push_back(mk(2'd2, 1'b1, 3'd2, 32'h10, 32'h11223344));
        q.push_back(mk(2'd2, 1'b1, 3'd0, 32'h13, 32'hAA000000));
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h10, 32'd0));
        run_queue();
        check("tp_byte", last_obs_rd, 32'hAA223344);
        q.push_back(mk(2'd2, 1'b1, 3'd1, 32'h10, 32'h00005566));
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h10, 32'd0));
        run_queue();
        check("tp_half", last_obs_rd, 32'hAA225566);

        // Misaligned, out-of-range and oversize accesses; memory untouched.
        q.push_back(mk(2'd2, 1'b1, 3'd2, 32'h02, 32'hFFFFFFFF));
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h400, 32'd0));
        q.push_back(mk(2'd2, 1'b1, 3'd2, 32'h400, 32'h0BADF00D));
        q.push_back(mk(2'd2, 1'b1, 3'd3, 32'h08, 32'h0BADF00D));
        q.push_back(mk(2'd2, 1'b1, 3'd1, 32'h11, 32'h0BADF00D));
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h00, 32'd0));
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h10, 32'd0));
        run_queue();
        check("tp_err_nochange", last_obs_rd, 32'hAA225566);

        // Back-to-back write/read forwarding, then BUSY between beats.
        q.push_back(mk(2'd2, 1'b1, 3'd2, 32'h20, 32'h12345678));
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h20, 32'd0));
        run_queue();
        check("tp_bypass", last_obs_rd, 32'h12345678);
        q.push_back(mk(2'd2, 1'b1, 3'd1, 32'h22, 32'hCAFE0000));
        q.push_back(mk(2'd1, 1'b0, 3'd2, 32'h24, 32'd0));
        q.push_back(mk(2'd3, 1'b0, 3'd2, 32'h20, 32'd0));
        run_queue();
        check("tp_busy", last_obs_rd, 32'hCAFE5678);

        // HSEL low: no access.
        begin
            xfer_t t;
            t = mk(2'd2, 1'b1, 3'd2, 32'h20, 32'h55555555);
            t.sel = 1'b0;
            q.push_back(t);
            q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h20, 32'd0));
            run_queue();
            check("tp_hsel0", last_obs_rd, 32'hCAFE5678);
        end

        // Reset during the data phase of a write drops the write.
        bus.HSEL = 1'b1; bus.HTRANS = 2'd2; bus.HADDR = 32'h30;
        bus.HWRITE = 1'b1; bus.HSIZE = 3'd2;
        @(posedge clk); #1;
        bus.HSEL = 1'b0; bus.HTRANS = 2'd0;
        bus.HWDATA = ~f_model_read(32'h30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_rdata = 32'd0;
        @(negedge clk);
        check("rst_mid_resp", {30'd0, bus.HREADYOUT, bus.HRESP}, 32'd2);
        check("rst_mid_hrdata", bus.HRDATA, 32'd0);
        @(posedge clk); #1;
        q.push_back(mk(2'd2, 1'b0, 3'd2, 32'h30, 32'd0));
        run_queue();

        random_traffic(400);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/adbg_ahb3_mem_slave.md
Name: adbg_ahb3_mem_slave

Overview:
- AHB3-Lite slave with word-organised internal memory.
- Acts as the responder at the other end of the debug bus master's AHB port (dbg_H* signals); used as debug scratch RAM and as the bench target for bus-interface debug sessions.
- Supports byte, halfword and word transfers, with pipelined address and data phases.
- Returns a two-cycle ERROR response for illegal accesses.
- Wait-state insertion is optional.

Parameters:
- ADDR_WIDTH, 32: HADDR width.
- DATA_WIDTH, 32: HWDATA/HRDATA width. Must be 32 or 64.
- MEM_DEPTH, 256: number of DATA_WIDTH words. Byte address range is 0 .. MEM_DEPTH*DATA_WIDTH/8-1.
- WAIT_STATES, 2: wait cycles per transfer. Used only with ADBG_AHB3_SLV_WAITSTATE_EN.

Ports:
- HCLK  in  1  clock; all logic on rising edge.
- HRESET  in  1  reset, synchronous, active-high.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_WIDTH  address.
- HWDATA  in  DATA_WIDTH  write data (data phase).
- HRDATA  out  DATA_WIDTH  read data.
- HWRITE  in  1  1=write.
- HSIZE  in  3  transfer size.
- HBURST  in  3  burst type; informational, every beat is decoded independently.
- HPROT  in  4  ignored.
- HTRANS  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- HMASTLOCK  in  1  ignored.
- HREADY  in  1  bus-level ready (previous transfer complete).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.

Behaviour:
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE. Memory contents are not cleared. Reset asserted mid-transfer aborts it; a pending write is dropped.
- Address phase is accepted when HSEL & HREADY & HTRANS[1]. At acceptance, register HADDR, HSIZE and HWRITE, plus a decoded error flag.
- IDLE and BUSY transfers, or HSEL=0: zero-wait OKAY; no memory access.
- Error conditions, checked at acceptance:
  - HSIZE > log2(DATA_WIDTH/8);
  - HADDR not aligned to HSIZE;
  - HADDR beyond the memory range.
- State machine: IDLE, WAIT, ERR1, ERR2.
- Acceptance, no error, zero waits: stay in IDLE; data phase completes next cycle with HREADYOUT=1.
- Acceptance with error:
  - → ERR1: HREADYOUT=0, HRESP=1.
  - → ERR2: HREADYOUT=1, HRESP=1.
  - → IDLE.
  - Error takes precedence over wait states.
  - No memory write occurs.
  - HRDATA is unchanged during the error response.
- WAIT (macro only): HREADYOUT=0, HRESP=0 for WAIT_STATES cycles, counted by a down-counter. Then return to IDLE with HREADYOUT=1.
- Read:
  - Memory word is indexed by HADDR[log2(MEM_DEPTH)+log2(DATA_WIDTH/8)-1 : log2(DATA_WIDTH/8)].
  - HRDATA carries the full word, little-endian lanes, valid in the cycle HREADYOUT=1 completes the data phase.
  - HRDATA holds its value until the next read completes.
- Write:
  - HWDATA is sampled in the completing data-phase cycle (HREADYOUT=1).
  - Byte-lane enables are derived from registered HSIZE and HADDR low bits; only enabled lanes are written.
- Back-to-back write to address A, then read of A: the read returns the newly written lanes (bypass/forwarding). Unwritten lanes return old contents.
- A new address phase may be presented during a waited data phase. It is accepted only when HREADY=1.
- Every beat of a burst (INCR/WRAP, SEQ) is treated as an independent transfer. There is no burst-boundary checking beyond the per-beat error rules.

Optional Feature:
- Macro ADBG_AHB3_SLV_WAITSTATE_EN.
- Defined: every accepted, non-error transfer inserts WAIT_STATES cycles of HREADYOUT=0 before completion. WAIT_STATES=0 behaves as zero-wait.
- Undefined: WAIT state and counter are not built; all OKAY transfers are zero-wait and WAIT_STATES is ignored.

Test Plan:
- Reset: hold HRESET for 2 cycles → HREADYOUT=1, HRESP=0, HRDATA=0. Then write word 0xDEADBEEF @0x10 and read @0x10 → HRDATA=0xDEADBEEF, zero-wait.
- Byte write 0xAA @0x13 over word 0x11223344 @0x10; read @0x10 → 0xAA223344. Halfword write 0x5566 @0x10; read @0x10 → 0xAA225566.
- Misaligned word access @0x02, then out-of-range access @0x400 (MEM_DEPTH=256, 32-bit): each produces cycles (HREADYOUT=0,HRESP=1) then (1,1); memory is unchanged.
- Pipelined write @0x20 = 0x12345678 immediately followed by read @0x20 → 0x12345678 (bypass). A BUSY inserted between beats → OKAY, no access.
- With ADBG_AHB3_SLV_WAITSTATE_EN, WAIT_STATES=2: read @0x10 → HREADYOUT low for exactly 2 cycles, then data. Error access → no wait cycles, immediate 2-cycle ERROR.
- HRESET asserted during WAIT of a write @0x30 → next cycle HREADYOUT=1, HRESP=0; later read @0x30 → old value.
